// File: rtl/multicycle_seq_if.sv
// Sequencer <-> datapath bundle: control-unit flags and handshakes in, enable strobes and status out.
interface multicycle_seq_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             halt_req;
  logic             is_jmp;
  logic             is_read_mem;
  logic             is_write_mem;
  logic             is_push;
  logic             is_pop;
  logic             reg_we;
  logic             mem_ready;
  logic             ir_load;
  logic             pc_inc;
  logic             pc_jmp;
  logic             rf_we;
  logic             mem_re;
  logic             mem_we;
  logic             stack_push;
  logic             stack_pop;
  logic             busy;
  logic             halted;
  logic             error;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;

  // master: the sequencer, which drives every datapath enable
  modport master (
    input  start, halt_req, is_jmp, is_read_mem, is_write_mem, is_push, is_pop,
           reg_we, mem_ready,
    output ir_load, pc_inc, pc_jmp, rf_we, mem_re, mem_we, stack_push, stack_pop,
           busy, halted, error, state, instr_count
  );

  modport slave (
    output start, halt_req, is_jmp, is_read_mem, is_write_mem, is_push, is_pop,
           reg_we, mem_ready,
    input  ir_load, pc_inc, pc_jmp, rf_we, mem_re, mem_we, stack_push, stack_pop,
           busy, halted, error, state, instr_count
  );
endinterface

// File: rtl/multicycle_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer gating all state-changing datapath enables.
module multicycle_seq #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  multicycle_seq_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERROR  = 3'd7
  } state_t;

  typedef struct packed {
    logic jmp;
    logic rd;
    logic wr;
    logic push;
    logic pop;
    logic we;
  } cls_t;

  typedef struct packed {
    logic ir_load;
    logic pc_inc;
    logic pc_jmp;
    logic rf_we;
    logic mem_re;
    logic mem_we;
    logic push;
    logic pop;
  } strobe_t;

  state_t           r_state, w_next;
  cls_t             r_cls, w_cls_in;
  strobe_t          w_sb;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_tmo;
  logic             r_halt_pend, r_halted;
  logic             w_retire, w_busy, w_halt_now, w_cls_bad, w_tmo_hit, w_stk;

  assign w_cls_in   = {bus.is_jmp, bus.is_read_mem, bus.is_write_mem,
                       bus.is_push, bus.is_pop, bus.reg_we};
  // at most one memory/stack class, and a jump excludes all of them
  assign w_cls_bad  = ($countones({w_cls_in.rd, w_cls_in.wr, w_cls_in.push, w_cls_in.pop}) > 1) ||
                      (w_cls_in.jmp && (w_cls_in.rd || w_cls_in.wr || w_cls_in.push || w_cls_in.pop));
  assign w_busy     = (r_state != S_IDLE) && (r_state != S_ERROR);
  assign w_halt_now = r_halt_pend || bus.halt_req;
  assign w_tmo_hit  = !bus.mem_ready && (r_tmo == 8'(TIMEOUT - 1));
  assign w_stk      = r_cls.push || r_cls.pop;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_sb     = '0;
    w_retire = 1'b0;
    case (r_state)
      S_IDLE:   if (bus.start) w_next = S_FETCH;
      S_FETCH: begin
        w_sb.ir_load = 1'b1;
        w_next       = S_DECODE;
      end
      S_DECODE: w_next = w_cls_bad ? S_ERROR : S_EXEC;
      S_EXEC: begin
        if (r_cls.jmp) begin
          w_sb.pc_jmp = 1'b1;
          w_retire    = 1'b1;
          w_next      = w_halt_now ? S_IDLE : S_FETCH;
        end else if (r_cls.rd || r_cls.wr || w_stk) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        w_sb.mem_re = r_cls.rd;
        w_sb.mem_we = r_cls.wr;
        w_sb.push   = r_cls.push;
        w_sb.pop    = r_cls.pop;
        if (w_stk || bus.mem_ready) w_next = S_WB;
        else if (w_tmo_hit)         w_next = S_ERROR;
      end
      S_WB: begin
        w_sb.pc_inc = 1'b1;
        w_sb.rf_we  = (r_cls.we || r_cls.rd || r_cls.pop) && !(r_cls.wr || r_cls.push);
        w_retire    = 1'b1;
        w_next      = w_halt_now ? S_IDLE : S_FETCH;
      end
      S_ERROR:  w_next = S_ERROR;
      default:  w_next = S_ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cls       <= '0;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_halt_pend <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      if (r_state == S_DECODE) r_cls <= w_cls_in;
      if (w_retire) r_cnt <= r_cnt + 1'b1;
      // counts only wait cycles: staying in MEM implies mem_ready was low
      r_tmo <= (r_state == S_MEM && w_next == S_MEM) ? r_tmo + 8'd1 : 8'd0;
      if (w_next == S_IDLE)          r_halt_pend <= 1'b0;
      else if (w_busy && bus.halt_req) r_halt_pend <= 1'b1;
      if (r_state == S_IDLE && bus.start)     r_halted <= 1'b0;
      else if (w_retire && w_next == S_IDLE)  r_halted <= 1'b1;
    end
  end

  assign bus.ir_load     = w_sb.ir_load;
  assign bus.pc_inc      = w_sb.pc_inc;
  assign bus.pc_jmp      = w_sb.pc_jmp;
  assign bus.rf_we       = w_sb.rf_we;
  assign bus.mem_re      = w_sb.mem_re;
  assign bus.mem_we      = w_sb.mem_we;
  assign bus.stack_push  = w_sb.push;
  assign bus.stack_pop   = w_sb.pop;
  assign bus.busy        = w_busy;
  assign bus.halted      = r_halted;
  assign bus.error       = (r_state == S_ERROR);
  assign bus.state       = r_state;
  assign bus.instr_count = r_cnt;
endmodule
